ctrl_decode_pipe: RTL and testbench

//  Registered decode stage for the 32-bit pipeline: maps opcode to the control word (EXE_CMD, WB/MEM enables,

---
 rtl/ctrl_decode_pipe.sv | 207 ++++++++++++++++++++
 tb/tb_ctrl_decode_pipe.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe
//   Registered decode stage between the IF/ID register and EXE. Maps the
//   opcode to a control word, loads it into the ID/EX control register, and
//   generates the PC / IF-ID hold request.
//   Hold requests come from two sources:
//   - load-use hazard detection against the load sitting in ID/EX;
//   - a small sequencer that keeps the pipe held while a multi-cycle MUL
//     occupies EXE.
//   Undefined opcodes are flagged.
//
// Ports
//   clk, rst_n         clock, async active-low reset
//   in_valid           IF/ID holds a valid instruction
//   opcode             instruction opcode
//   src1, src2, dest   register indices of the instruction in IF/ID
//   ex_stall           downstream hold: ID/EX and the MUL counter freeze
//   flush              branch taken: kill ID/EX contents and the MUL sequence
//   id_*               registered ID/EX control word
//   stall_req          combinational: hold PC and IF/ID this cycle
//   dbg_mul_busy       sequencer state (1 = BUSY), for observation only
//
// Flow control
//   An instruction presented with in_valid is consumed at a clock edge only
//   when stall_req is low, ex_stall is low and flush is low. While stall_req
//   is high, the upstream stage must keep presenting the same instruction.
//   ex_stall freezes ID/EX but never raises stall_req on its own.
module ctrl_decode_pipe #(
  parameter int OPCODE_W   = 6,
  parameter int EXE_CMD_W  = 4,
  parameter int REG_ADDR_W = 5,
  parameter int MUL_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic [REG_ADDR_W-1:0] src2,
  input  logic [REG_ADDR_W-1:0] dest,
  input  logic                  ex_stall,
  input  logic                  flush,
  output logic                  id_valid,
  output logic [EXE_CMD_W-1:0]  id_exe_cmd,
  output logic                  id_wb_en,
  output logic                  id_mem_r_en,
  output logic                  id_mem_w_en,
  output logic                  id_is_imm,
  output logic [1:0]            id_br_type,
  output logic [REG_ADDR_W-1:0] id_dest,
  output logic                  id_illegal,
  output logic                  stall_req,
  output logic                  dbg_mul_busy
);

  localparam int CNT_W = $clog2(MUL_CYCLES);

  localparam logic [OPCODE_W-1:0] OP_NOP  = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(6'b000001);
  localparam logic [OPCODE_W-1:0] OP_MUL  = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(6'b000011);
  localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(6'b000101);
  localparam logic [OPCODE_W-1:0] OP_OR   = OPCODE_W'(6'b000110);
  localparam logic [OPCODE_W-1:0] OP_NOR  = OPCODE_W'(6'b000111);
  localparam logic [OPCODE_W-1:0] OP_XOR  = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_SLA  = OPCODE_W'(6'b001001);
  localparam logic [OPCODE_W-1:0] OP_SLL  = OPCODE_W'(6'b001010);
  localparam logic [OPCODE_W-1:0] OP_SRA  = OPCODE_W'(6'b001011);
  localparam logic [OPCODE_W-1:0] OP_SRL  = OPCODE_W'(6'b001100);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b100000);
  localparam logic [OPCODE_W-1:0] OP_SUBI = OPCODE_W'(6'b100001);
  localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(6'b100100);
  localparam logic [OPCODE_W-1:0] OP_ST   = OPCODE_W'(6'b100101);
  localparam logic [OPCODE_W-1:0] OP_BEZ  = OPCODE_W'(6'b101000);
  localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(6'b101001);
  localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(6'b101010);

  localparam logic [EXE_CMD_W-1:0] CMD_ADD = EXE_CMD_W'(4'b0000);
  localparam logic [EXE_CMD_W-1:0] CMD_MUL = EXE_CMD_W'(4'b0011);
  localparam logic [EXE_CMD_W-1:0] CMD_SUB = EXE_CMD_W'(4'b0010);
  localparam logic [EXE_CMD_W-1:0] CMD_AND = EXE_CMD_W'(4'b0100);
  localparam logic [EXE_CMD_W-1:0] CMD_OR  = EXE_CMD_W'(4'b0101);
  localparam logic [EXE_CMD_W-1:0] CMD_NOR = EXE_CMD_W'(4'b0110);
  localparam logic [EXE_CMD_W-1:0] CMD_XOR = EXE_CMD_W'(4'b0111);
  localparam logic [EXE_CMD_W-1:0] CMD_SHL = EXE_CMD_W'(4'b1000);
  localparam logic [EXE_CMD_W-1:0] CMD_SRA = EXE_CMD_W'(4'b1001);
  localparam logic [EXE_CMD_W-1:0] CMD_SRL = EXE_CMD_W'(4'b1010);

  typedef enum logic {IDLE, BUSY} mul_state_t;

  mul_state_t         state;
  logic [CNT_W-1:0]   cnt;

  logic [EXE_CMD_W-1:0] dec_cmd;
  logic                 dec_wb, dec_mr, dec_mw, dec_imm, dec_ill;
  logic [1:0]           dec_br;
  logic                 uses_src2, hazard, busy;
  logic                 nxt_valid, update_en, mul_load;

  // Opcode decode (pure combinational lookup)
  always_comb begin
    dec_cmd = '0;
    dec_wb  = 1'b0;
    dec_mr  = 1'b0;
    dec_mw  = 1'b0;
    dec_imm = 1'b0;
    dec_br  = 2'b00;
    dec_ill = 1'b0;
    case (opcode)
      OP_NOP:         ;
      OP_ADD:         dec_wb = 1'b1;
      OP_MUL:         begin dec_cmd = CMD_MUL; dec_wb = 1'b1; end
      OP_SUB:         begin dec_cmd = CMD_SUB; dec_wb = 1'b1; end
      OP_AND:         begin dec_cmd = CMD_AND; dec_wb = 1'b1; end
      OP_OR:          begin dec_cmd = CMD_OR;  dec_wb = 1'b1; end
      OP_NOR:         begin dec_cmd = CMD_NOR; dec_wb = 1'b1; end
      OP_XOR:         begin dec_cmd = CMD_XOR; dec_wb = 1'b1; end
      OP_SLA, OP_SLL: begin dec_cmd = CMD_SHL; dec_wb = 1'b1; end
      OP_SRA:         begin dec_cmd = CMD_SRA; dec_wb = 1'b1; end
      OP_SRL:         begin dec_cmd = CMD_SRL; dec_wb = 1'b1; end
      OP_ADDI:        begin dec_cmd = CMD_ADD; dec_wb = 1'b1; dec_imm = 1'b1; end
      OP_SUBI:        begin dec_cmd = CMD_SUB; dec_wb = 1'b1; dec_imm = 1'b1; end
      OP_LD:          begin dec_wb = 1'b1; dec_mr = 1'b1; dec_imm = 1'b1; end
      OP_ST:          begin dec_mw = 1'b1; dec_imm = 1'b1; end
      OP_BEZ:         dec_br = 2'b01;
      OP_BNE:         dec_br = 2'b10;
      OP_JMP:         dec_br = 2'b11;
      default:        dec_ill = 1'b1;
    endcase
  end

  // The whole R-type opcode range reads src2, including the unused code inside it
  assign uses_src2 = ((opcode >= OP_ADD) && (opcode <= OP_SRL)) ||
                     (opcode == OP_ST) || (opcode == OP_BNE);

  assign hazard = id_valid && id_mem_r_en && (id_dest != '0) && in_valid &&
                  ((id_dest == src1) || (uses_src2 && (id_dest == src2)));
  assign busy         = (state == BUSY);
  assign stall_req    = hazard || busy;
  assign dbg_mul_busy = busy;

  // flush always writes a bubble; otherwise ex_stall freezes the register.
  // A bubble is written on flush or stall_req; a real word only when neither.
  assign update_en = flush || !ex_stall;
  assign nxt_valid = !flush && !stall_req && in_valid;
  assign mul_load  = update_en && nxt_valid && (opcode == OP_MUL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid    <= 1'b0;
      id_exe_cmd  <= '0;
      id_wb_en    <= 1'b0;
      id_mem_r_en <= 1'b0;
      id_mem_w_en <= 1'b0;
      id_is_imm   <= 1'b0;
      id_br_type  <= 2'b00;
      id_dest     <= '0;
      id_illegal  <= 1'b0;
    end else if (update_en) begin
      id_valid    <= nxt_valid;
      id_exe_cmd  <= nxt_valid ? dec_cmd : '0;
      id_wb_en    <= nxt_valid && dec_wb;
      id_mem_r_en <= nxt_valid && dec_mr;
      id_mem_w_en <= nxt_valid && dec_mw;
      id_is_imm   <= nxt_valid && dec_imm;
      id_br_type  <= nxt_valid ? dec_br : 2'b00;
      id_dest     <= nxt_valid ? dest : '0;
      id_illegal  <= nxt_valid && dec_ill;
    end
  end

  // MUL sequencer: the counter holds the remaining EXE cycles of the MUL.
  // The pipe is held while BUSY, which gives MUL_CYCLES-1 hold cycles
  // when ex_stall stays low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mul_load) begin
            state <= BUSY;
            cnt   <= CNT_W'(MUL_CYCLES - 1);
          end
        end
        BUSY: begin
          if (!ex_stall) begin
            if (cnt == CNT_W'(1)) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Testbench for ctrl_decode_pipe.
// A reference model tracks the ID/EX word and the number of MUL hold cycles
// still owed. The bench applies directed sequences and random traffic, then
// compares the DUT against the model every cycle.
`timescale 1ns/1ps
module tb_ctrl_decode_pipe;

  localparam int MUL_CYCLES = 4;
  localparam int W = 17;  // {valid, cmd[4], wb, mr, mw, imm, br[2], dest[5], ill}

  typedef struct {
    logic [5:0] op;
    logic [3:0] cmd;
    logic [3:0] flags;  // {wb, mem_r, mem_w, imm}
    logic [1:0] br;
    logic       ill;
  } vec_t;

  vec_t vtab [20];

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [5:0] opcode;
  logic [4:0] src1, src2, dest;
  logic       ex_stall, flush;
  logic       id_valid, id_wb_en, id_mem_r_en, id_mem_w_en, id_is_imm, id_illegal;
  logic [3:0] id_exe_cmd;
  logic [1:0] id_br_type;
  logic [4:0] id_dest;
  logic       stall_req, dbg_mul_busy;

  always #5 clk = ~clk;

  ctrl_decode_pipe #(
    .OPCODE_W(6), .EXE_CMD_W(4), .REG_ADDR_W(5), .MUL_CYCLES(MUL_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .opcode(opcode),
    .src1(src1), .src2(src2), .dest(dest), .ex_stall(ex_stall), .flush(flush),
    .id_valid(id_valid), .id_exe_cmd(id_exe_cmd), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .id_mem_w_en(id_mem_w_en), .id_is_imm(id_is_imm),
    .id_br_type(id_br_type), .id_dest(id_dest), .id_illegal(id_illegal),
    .stall_req(stall_req), .dbg_mul_busy(dbg_mul_busy)
  );

  logic [W-1:0] dut_w;
  assign dut_w = {id_valid, id_exe_cmd, id_wb_en, id_mem_r_en, id_mem_w_en,
                  id_is_imm, id_br_type, id_dest, id_illegal};

  // ---------------- scoreboard / model state ----------------
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_w;          // expected ID/EX word
  int           m_mul_left;   // MUL hold cycles still owed
  logic         last_stall;   // stall_req sampled in the last drive_cycle

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [5:0] op, input logic [3:0] cmd,
                              input logic [3:0] flags, input logic [1:0] br, input logic ill);
    vec_t v;
    v.op = op; v.cmd = cmd; v.flags = flags; v.br = br; v.ill = ill;
    return v;
  endfunction

  // Expected ID/EX word for a valid instruction, found by table lookup
  function automatic logic [W-1:0] model_word(input logic [5:0] op, input logic [4:0] d);
    logic [W-1:0] w;
    w = {1'b1, 4'h0, 4'h0, 2'b00, d, 1'b1};
    for (int i = 0; i < 20; i++)
      if (!vtab[i].ill && vtab[i].op == op)
        w = {1'b1, vtab[i].cmd, vtab[i].flags, vtab[i].br, d, 1'b0};
    return w;
  endfunction

  function automatic logic uses2(input logic [5:0] op);
    return ((op >= 6'd1) && (op <= 6'd12)) || (op == 6'b100101) || (op == 6'b101001);
  endfunction

  // ---------------- driver tasks ----------------
  // Called at posedge+1; leaves at the next posedge+1 after comparing.
  task automatic drive_cycle(input logic iv, input logic [5:0] op, input logic [4:0] s1,
                             input logic [4:0] s2, input logic [4:0] d,
                             input logic exs, input logic fl);
    logic m_haz, m_stall;
    in_valid = iv; opcode = op; src1 = s1; src2 = s2; dest = d;
    ex_stall = exs; flush = fl;
    #1;
    m_haz = m_w[16] && m_w[10] && (m_w[5:1] != 5'd0) && iv &&
            ((m_w[5:1] == s1) || (uses2(op) && (m_w[5:1] == s2)));
    m_stall = m_haz || (m_mul_left > 0);
    last_stall = stall_req;
    check("stall_req", 32'(stall_req), 32'(m_stall));
    if (fl) begin
      m_w = '0;
      m_mul_left = 0;
    end else if (!exs) begin
      if (m_mul_left > 0) m_mul_left--;
      if (m_stall || !iv) m_w = '0;
      else begin
        m_w = model_word(op, d);
        if (op == 6'b000010) m_mul_left = MUL_CYCLES - 1;
      end
    end
    exp_q.push_back(m_w);
    @(posedge clk);
    #1;
    check("id_word", 32'(dut_w), 32'(exp_q.pop_front()));
    check("mul_busy", 32'(dbg_mul_busy), 32'(m_mul_left > 0));
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic drain_mul();
    for (int k = 0; k < 20 && m_mul_left > 0; k++) idle_cycle();
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    m_w = '0;
    m_mul_left = 0;
    exp_q.delete();
    for (int k = 0; k < cycles; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      opcode   = 6'($urandom);
      src1     = 5'($urandom);
      src2     = 5'($urandom);
      dest     = 5'($urandom);
      ex_stall = 1'($urandom_range(0, 1));
      flush    = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("reset_word", 32'(dut_w), 32'(0));
      check("reset_stall", 32'(stall_req), 32'(0));
    end
    rst_n = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int cnt;
    rst_n = 1'b0; in_valid = 1'b0; opcode = '0; src1 = '0; src2 = '0; dest = '0;
    ex_stall = 1'b0; flush = 1'b0; last_stall = 1'b0;
    m_w = '0; m_mul_left = 0;

    vtab[0]  = mk(6'b000000, 4'b0000, 4'b0000, 2'b00, 1'b0); // NOP
    vtab[1]  = mk(6'b000001, 4'b0000, 4'b1000, 2'b00, 1'b0); // ADD
    vtab[2]  = mk(6'b000010, 4'b0011, 4'b1000, 2'b00, 1'b0); // MUL
    vtab[3]  = mk(6'b000011, 4'b0010, 4'b1000, 2'b00, 1'b0); // SUB
    vtab[4]  = mk(6'b000101, 4'b0100, 4'b1000, 2'b00, 1'b0); // AND
    vtab[5]  = mk(6'b000110, 4'b0101, 4'b1000, 2'b00, 1'b0); // OR
    vtab[6]  = mk(6'b000111, 4'b0110, 4'b1000, 2'b00, 1'b0); // NOR
    vtab[7]  = mk(6'b001000, 4'b0111, 4'b1000, 2'b00, 1'b0); // XOR
    vtab[8]  = mk(6'b001001, 4'b1000, 4'b1000, 2'b00, 1'b0); // SLA
    vtab[9]  = mk(6'b001010, 4'b1000, 4'b1000, 2'b00, 1'b0); // SLL
    vtab[10] = mk(6'b001011, 4'b1001, 4'b1000, 2'b00, 1'b0); // SRA
    vtab[11] = mk(6'b001100, 4'b1010, 4'b1000, 2'b00, 1'b0); // SRL
    vtab[12] = mk(6'b100000, 4'b0000, 4'b1001, 2'b00, 1'b0); // ADDI
    vtab[13] = mk(6'b100001, 4'b0010, 4'b1001, 2'b00, 1'b0); // SUBI
    vtab[14] = mk(6'b100100, 4'b0000, 4'b1101, 2'b00, 1'b0); // LD
    vtab[15] = mk(6'b100101, 4'b0000, 4'b0011, 2'b00, 1'b0); // ST
    vtab[16] = mk(6'b101000, 4'b0000, 4'b0000, 2'b01, 1'b0); // BEZ
    vtab[17] = mk(6'b101001, 4'b0000, 4'b0000, 2'b10, 1'b0); // BNE
    vtab[18] = mk(6'b101010, 4'b0000, 4'b0000, 2'b11, 1'b0); // JMP
    vtab[19] = mk(6'b111111, 4'b0000, 4'b0000, 2'b00, 1'b1); // undefined

    // Reset with random inputs, then a first ADD
    #2;
    apply_reset(3);
    drive_cycle(1'b1, 6'b000001, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0);
    check("first_add_cmd", 32'(id_exe_cmd), 32'(4'b0000));
    check("first_add_wb", 32'(id_wb_en), 32'(1));

    // Table sweep
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b1, vtab[i].op, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0);
      check("tab_valid", 32'(id_valid), 32'(1));
      check("tab_cmd", 32'(id_exe_cmd), 32'(vtab[i].cmd));
      check("tab_flags", 32'({id_wb_en, id_mem_r_en, id_mem_w_en, id_is_imm}), 32'(vtab[i].flags));
      check("tab_br", 32'(id_br_type), 32'(vtab[i].br));
      check("tab_ill", 32'(id_illegal), 32'(vtab[i].ill));
      drain_mul();
    end

    // Load-use: exactly one bubble, then the dependent ADD
    drive_cycle(1'b1, 6'b100100, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0);
    drive_cycle(1'b1, 6'b000001, 5'd3, 5'd0, 5'd4, 1'b0, 1'b0);
    check("lu_stall", 32'(last_stall), 32'(1));
    check("lu_bubble", 32'(id_valid), 32'(0));
    drive_cycle(1'b1, 6'b000001, 5'd3, 5'd0, 5'd4, 1'b0, 1'b0);
    check("lu_release", 32'(last_stall), 32'(0));
    check("lu_add_word", 32'(dut_w), 32'({1'b1, 4'b0000, 4'b1000, 2'b00, 5'd4, 1'b0}));
    // Load to r0 never creates a hazard
    drive_cycle(1'b1, 6'b100100, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    drive_cycle(1'b1, 6'b000001, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0);
    check("lu_r0_nostall", 32'(last_stall), 32'(0));

    // MUL: MUL_CYCLES-1 hold cycles
    drive_cycle(1'b1, 6'b000010, 5'd1, 5'd2, 5'd6, 1'b0, 1'b0);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      idle_cycle();
      if (last_stall) cnt++;
    end
    check("mul_hold_cycles", 32'(cnt), 32'(MUL_CYCLES - 1));
    // MUL with ex_stall high for two cycles mid-sequence
    drive_cycle(1'b1, 6'b000010, 5'd1, 5'd2, 5'd6, 1'b0, 1'b0);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      drive_cycle(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, (k == 1 || k == 2), 1'b0);
      if (last_stall) cnt++;
    end
    check("mul_hold_exstall", 32'(cnt), 32'(MUL_CYCLES + 1));

    // Flush during BUSY
    drive_cycle(1'b1, 6'b000010, 5'd1, 5'd2, 5'd6, 1'b0, 1'b0);
    drive_cycle(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    check("flush_busy_valid", 32'(id_valid), 32'(0));
    check("flush_busy_state", 32'(dbg_mul_busy), 32'(0));
    check("flush_busy_stall", 32'(stall_req), 32'(0));
    // Flush together with a MUL load
    drive_cycle(1'b1, 6'b000010, 5'd1, 5'd2, 5'd6, 1'b0, 1'b1);
    check("flush_load_valid", 32'(id_valid), 32'(0));
    check("flush_load_state", 32'(dbg_mul_busy), 32'(0));
    check("flush_load_stall", 32'(stall_req), 32'(0));

    // ex_stall holds a loaded SUBI for three cycles
    drive_cycle(1'b1, 6'b100001, 5'd1, 5'd2, 5'd7, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1'b1, 6'b000001, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0);
      check("exstall_hold", 32'(dut_w), 32'({1'b1, 4'b0010, 4'b1001, 2'b00, 5'd7, 1'b0}));
    end
    idle_cycle();

    // Asynchronous reset in the middle of a MUL
    drive_cycle(1'b1, 6'b000010, 5'd1, 5'd2, 5'd6, 1'b0, 1'b0);
    idle_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_word", 32'(dut_w), 32'(0));
    check("async_rst_state", 32'(dbg_mul_busy), 32'(0));
    check("async_rst_stall", 32'(stall_req), 32'(0));
    @(posedge clk);
    #1;
    apply_reset(2);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      logic [5:0] op;
      if ($urandom_range(0, 9) < 8) op = vtab[$urandom_range(0, 19)].op;
      else op = 6'($urandom);
      drive_cycle(($urandom_range(0, 9) < 8), op,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 8));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
